// File: rtl/cover_hit_collector_if.sv
// rtl/cover_hit_collector_if.sv - read request/response handshake for cover_hit_collector
interface cover_hit_collector_if #(
    parameter int NUM_BINS = 4,
    parameter int CNT_W    = 8,
    parameter int TS_W     = 16
);
    localparam int IDX_W = $clog2(NUM_BINS) + 1;

    logic             rd_req_i;
    logic [IDX_W-1:0] rd_idx_i;
    logic             rd_req_rdy_o;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [CNT_W-1:0] rd_count_o;
    logic [TS_W-1:0]  rd_first_o;
    logic             rd_err_o;

    modport slave (
        input  rd_req_i, rd_idx_i, rd_ready_i,
        output rd_req_rdy_o, rd_valid_o, rd_count_o, rd_first_o, rd_err_o
    );

    modport master (
        output rd_req_i, rd_idx_i, rd_ready_i,
        input  rd_req_rdy_o, rd_valid_o, rd_count_o, rd_first_o, rd_err_o
    );
endinterface

// File: rtl/cover_hit_collector.sv
// rtl/cover_hit_collector.sv - per-bin hit counters, first-hit stamps and coverage flags with a read port
module cover_hit_collector #(
    parameter int NUM_BINS  = 4,
    parameter int CNT_W     = 8,
    parameter int TS_W      = 16,
    parameter int EDGE_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [NUM_BINS-1:0] hit_i,
    input  logic                clear_i,
    cover_hit_collector_if.slave rd,
    output logic [NUM_BINS-1:0] covered_o,
    output logic                all_covered_o,
    output logic                all_cov_pulse_o
);
    localparam int IDX_W = $clog2(NUM_BINS) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TS_W-1:0]  TS_MAX  = '1;

    typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;
    state_t state, state_nxt;

    logic [TS_W-1:0]     stamp, stamp_nxt;
    logic [NUM_BINS-1:0] prev, prev_nxt, hit_ev, covered_nxt;
    logic                all_nxt;
    logic [CNT_W-1:0]    count [NUM_BINS];
    logic [CNT_W-1:0]    count_nxt [NUM_BINS];
    logic [TS_W-1:0]     first [NUM_BINS];
    logic [TS_W-1:0]     first_nxt [NUM_BINS];

    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] snap_count, snap_count_nxt;
    logic [TS_W-1:0]  snap_first, snap_first_nxt;
    logic             snap_err, snap_err_nxt;

    always_comb begin
        hit_ev      = sample_en ? (hit_i & ((EDGE_MODE != 0) ? ~prev : {NUM_BINS{1'b1}})) : '0;
        prev_nxt    = clear_i ? '0 : (sample_en ? hit_i : prev);
        stamp_nxt   = stamp;
        if (clear_i)
            stamp_nxt = '0;
        else if (sample_en && stamp != TS_MAX)
            stamp_nxt = stamp + TS_W'(1);
        covered_nxt = clear_i ? '0 : (covered_o | hit_ev);
        all_nxt     = &covered_nxt;
        for (int b = 0; b < NUM_BINS; b++) begin
            count_nxt[b] = count[b];
            first_nxt[b] = first[b];
            if (clear_i) begin
                count_nxt[b] = '0;
                first_nxt[b] = '0;
            end else if (hit_ev[b]) begin
                if (count[b] != CNT_MAX)
                    count_nxt[b] = count[b] + CNT_W'(1);
                // first-hit stamp is the value before this edge's increment
                if (!covered_o[b])
                    first_nxt[b] = stamp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp           <= '0;
            prev            <= '0;
            covered_o       <= '0;
            all_covered_o   <= 1'b0;
            all_cov_pulse_o <= 1'b0;
            for (int b = 0; b < NUM_BINS; b++) begin
                count[b] <= '0;
                first[b] <= '0;
            end
        end else begin
            stamp           <= stamp_nxt;
            prev            <= prev_nxt;
            covered_o       <= covered_nxt;
            all_covered_o   <= all_nxt;
            all_cov_pulse_o <= all_nxt & ~all_covered_o;
            for (int b = 0; b < NUM_BINS; b++) begin
                count[b] <= count_nxt[b];
                first[b] <= first_nxt[b];
            end
        end
    end

    // snapshot takes the values being written on the capture edge
    always_comb begin
        snap_err_nxt   = (idx_q >= IDX_W'(NUM_BINS));
        snap_count_nxt = '0;
        snap_first_nxt = '0;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (idx_q == IDX_W'(b)) begin
                snap_count_nxt = count_nxt[b];
                snap_first_nxt = first_nxt[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd.rd_req_i) state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (rd.rd_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            snap_count <= '0;
            snap_first <= '0;
            snap_err   <= 1'b0;
        end else begin
            if (state == IDLE && rd.rd_req_i)
                idx_q <= rd.rd_idx_i;
            if (state == CAPT) begin
                snap_count <= snap_count_nxt;
                snap_first <= snap_first_nxt;
                snap_err   <= snap_err_nxt;
            end
        end
    end

    always_comb begin
        rd.rd_req_rdy_o = (state == IDLE);
        rd.rd_valid_o   = (state == RESP);
        rd.rd_count_o   = (state == RESP) ? snap_count : '0;
        rd.rd_first_o   = (state == RESP) ? snap_first : '0;
        rd.rd_err_o     = (state == RESP) ? snap_err : 1'b0;
    end
endmodule

// File: tb/tb_cover_hit_collector.sv
// tb/tb_cover_hit_collector.sv - randomized and directed checks of cover_hit_collector against a reference model
module tb_cover_hit_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       clear;
    logic [3:0] hit;
    logic       rd_req;
    logic       rd_ready;
    logic [2:0] rd_idx;
    logic [3:0] cov0, cov1;
    logic       all0, all1, pulse0, pulse1;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt_m   [2][4];
    int first_m [2][4];
    bit cov_m   [2][4];
    bit prev_m  [2][4];
    bit all_m   [2];
    bit pulse_m [2];
    int stamp_m;

    cover_hit_collector_if #(.NUM_BINS(4), .CNT_W(8), .TS_W(16)) rif0 ();
    cover_hit_collector_if #(.NUM_BINS(4), .CNT_W(8), .TS_W(16)) rif1 ();

    assign rif0.rd_req_i   = rd_req;
    assign rif0.rd_idx_i   = rd_idx;
    assign rif0.rd_ready_i = rd_ready;
    assign rif1.rd_req_i   = rd_req;
    assign rif1.rd_idx_i   = rd_idx;
    assign rif1.rd_ready_i = rd_ready;

    cover_hit_collector #(.NUM_BINS(4), .CNT_W(8), .TS_W(16), .EDGE_MODE(0)) dut_level (
        .clk(clk), .rst(rst), .sample_en(sample_en), .hit_i(hit), .clear_i(clear),
        .rd(rif0.slave), .covered_o(cov0), .all_covered_o(all0), .all_cov_pulse_o(pulse0)
    );

    cover_hit_collector #(.NUM_BINS(4), .CNT_W(8), .TS_W(16), .EDGE_MODE(1)) dut_edge (
        .clk(clk), .rst(rst), .sample_en(sample_en), .hit_i(hit), .clear_i(clear),
        .rd(rif1.slave), .covered_o(cov1), .all_covered_o(all1), .all_cov_pulse_o(pulse1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 4; b++) begin
                cnt_m[m][b] = 0; first_m[m][b] = 0; cov_m[m][b] = 0; prev_m[m][b] = 0;
            end
            all_m[m] = 0; pulse_m[m] = 0;
        end
        stamp_m = 0;
    endtask

    task automatic model_step();
        bit ev, now_all;
        if (rst || clear) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            now_all = 1;
            for (int b = 0; b < 4; b++) begin
                ev = sample_en && hit[b] && (m == 0 || !prev_m[m][b]);
                if (ev) begin
                    if (cnt_m[m][b] < 255) cnt_m[m][b]++;
                    if (!cov_m[m][b]) begin
                        first_m[m][b] = stamp_m;
                        cov_m[m][b] = 1;
                    end
                end
                if (sample_en) prev_m[m][b] = hit[b];
                if (!cov_m[m][b]) now_all = 0;
            end
            pulse_m[m] = now_all && !all_m[m];
            all_m[m] = now_all;
        end
        if (sample_en && stamp_m < 65535) stamp_m++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_flags();
        logic [3:0] e0, e1;
        for (int b = 0; b < 4; b++) begin
            e0[b] = cov_m[0][b];
            e1[b] = cov_m[1][b];
        end
        chk("covered_lvl", 32'(cov0), 32'(e0));
        chk("covered_edg", 32'(cov1), 32'(e1));
        chk("all_lvl", 32'(all0), 32'(all_m[0]));
        chk("all_edg", 32'(all1), 32'(all_m[1]));
        chk("pulse_lvl", 32'(pulse0), 32'(pulse_m[0]));
        chk("pulse_edg", 32'(pulse1), 32'(pulse_m[1]));
    endtask

    task automatic read_check(input int idx, input string tag);
        int ec, ef, ee;
        rd_idx = 3'(idx); rd_req = 1'b1; rd_ready = 1'b0;
        chk({tag, "_rdy"}, 32'(rif0.rd_req_rdy_o), 1);
        cycle();
        rd_req = 1'b0;
        chk({tag, "_lat1"}, 32'(rif0.rd_valid_o), 0);
        cycle();
        chk({tag, "_valid_lvl"}, 32'(rif0.rd_valid_o), 1);
        chk({tag, "_valid_edg"}, 32'(rif1.rd_valid_o), 1);
        for (int m = 0; m < 2; m++) begin
            if (idx < 4) begin
                ec = cnt_m[m][idx]; ef = first_m[m][idx]; ee = 0;
            end else begin
                ec = 0; ef = 0; ee = 1;
            end
            chk({tag, "_count"}, m == 0 ? 32'(rif0.rd_count_o) : 32'(rif1.rd_count_o), ec);
            chk({tag, "_first"}, m == 0 ? 32'(rif0.rd_first_o) : 32'(rif1.rd_first_o), ef);
            chk({tag, "_err"},   m == 0 ? 32'(rif0.rd_err_o)   : 32'(rif1.rd_err_o),   ee);
        end
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        chk({tag, "_done"}, 32'(rif0.rd_valid_o), 0);
        chk({tag, "_zero"}, 32'(rif0.rd_count_o), 0);
        chk({tag, "_idle"}, 32'(rif0.rd_req_rdy_o), 1);
    endtask

    task automatic run_cycles(input int n, input logic [3:0] h, input logic se);
        hit = h; sample_en = se;
        for (int i = 0; i < n; i++) begin
            cycle();
            check_flags();
        end
    endtask

    initial begin
        int pulses;
        logic [31:0] hc0, hf0, hc1, hf1;
        rst = 1'b1; sample_en = 1'b0; clear = 1'b0; hit = '0;
        rd_req = 1'b0; rd_ready = 1'b0; rd_idx = '0;
        model_reset();
        cycle(); cycle();
        chk("rst_rdy", 32'(rif0.rd_req_rdy_o), 1);
        chk("rst_valid", 32'(rif0.rd_valid_o), 0);
        chk("rst_cov", 32'(cov0), 0);
        chk("rst_all", 32'(all0), 0);
        chk("rst_pulse", 32'(pulse0), 0);
        chk("rst_count", 32'(rif0.rd_count_o), 0);
        rst = 1'b0;

        // level count starting at stamp 5
        run_cycles(5, 4'b0000, 1'b1);
        run_cycles(10, 4'b0001, 1'b1);
        hit = '0;
        chk("t2_cov", 32'(cov0), 32'b0001);
        read_check(0, "t2");
        chk("t2_count_const", 32'(rif0.rd_count_o), 0);
        rd_idx = 3'd0; rd_req = 1'b1; cycle(); rd_req = 1'b0; cycle();
        chk("t2_count10", 32'(rif0.rd_count_o), 10);
        chk("t2_first5", 32'(rif0.rd_first_o), 5);
        chk("t2_edge_count1", 32'(rif1.rd_count_o), 1);
        rd_ready = 1'b1; cycle(); rd_ready = 1'b0;

        // saturation
        run_cycles(300, 4'b0010, 1'b1);
        hit = '0;
        read_check(1, "t3a");
        run_cycles(10, 4'b0010, 1'b1);
        hit = '0;
        read_check(1, "t3b");
        chk("t3_sat_model", 32'(cnt_m[0][1]), 255);

        // edge mode, including a rise hidden by sample_en=0
        clear = 1'b1; cycle(); clear = 1'b0;
        check_flags();
        foreach (hit[i]) ;
        for (int i = 0; i < 7; i++) begin
            logic [6:0] pat;
            pat = 7'b0110110;
            run_cycles(1, {1'b0, pat[6-i], 2'b00}, 1'b1);
        end
        run_cycles(1, 4'b0000, 1'b1);
        run_cycles(1, 4'b0100, 1'b0);
        run_cycles(1, 4'b0000, 1'b1);
        rd_idx = 3'd2; rd_req = 1'b1; cycle(); rd_req = 1'b0; cycle();
        chk("t4_edge_count2", 32'(rif1.rd_count_o), 2);
        chk("t4_level_count4", 32'(rif0.rd_count_o), 4);
        rd_ready = 1'b1; cycle(); rd_ready = 1'b0;

        // coverage progression and single pulse
        clear = 1'b1; cycle(); clear = 1'b0;
        check_flags();
        run_cycles(1, 4'b1000, 1'b1); run_cycles(1, 4'b0000, 1'b1);
        run_cycles(1, 4'b0001, 1'b1); run_cycles(1, 4'b0000, 1'b1);
        run_cycles(1, 4'b0100, 1'b1); run_cycles(1, 4'b0000, 1'b1);
        chk("t5_not_all", 32'(all0), 0);
        run_cycles(1, 4'b0010, 1'b1);
        chk("t5_all", 32'(all0), 1);
        chk("t5_all_edg", 32'(all1), 1);
        pulses = int'(pulse0);
        for (int i = 0; i < 5; i++) begin
            run_cycles(1, 4'b0000, 1'b1);
            pulses += int'(pulse0);
        end
        chk("t5_one_pulse", 32'(pulses), 1);
        clear = 1'b1; cycle(); clear = 1'b0;
        chk("t5_clr_cov", 32'(cov0), 0);
        chk("t5_clr_all", 32'(all0), 0);
        pulses = int'(pulse0);
        for (int i = 0; i < 3; i++) begin
            run_cycles(1, 4'b0000, 1'b1);
            pulses += int'(pulse0);
        end
        chk("t5_clr_no_pulse", 32'(pulses), 0);

        // out-of-range read and held response across clears
        run_cycles(3, 4'b0001, 1'b1);
        read_check(5, "t6_err");
        rd_idx = 3'd0; rd_req = 1'b1; rd_ready = 1'b0; cycle(); rd_req = 1'b0; cycle();
        hc0 = 32'(cnt_m[0][0]); hf0 = 32'(first_m[0][0]);
        hc1 = 32'(cnt_m[1][0]); hf1 = 32'(first_m[1][0]);
        chk("t6_hold_nz", 32'(rif0.rd_count_o != 0), 1);
        for (int i = 0; i < 20; i++) begin
            hit = 4'($urandom); sample_en = 1'b1; clear = (i % 5 == 2);
            cycle();
            chk("t6_hold_valid", 32'(rif0.rd_valid_o), 1);
            chk("t6_hold_cnt_lvl", 32'(rif0.rd_count_o), hc0);
            chk("t6_hold_fst_lvl", 32'(rif0.rd_first_o), hf0);
            chk("t6_hold_cnt_edg", 32'(rif1.rd_count_o), hc1);
            chk("t6_hold_fst_edg", 32'(rif1.rd_first_o), hf1);
        end
        clear = 1'b0; hit = '0; rd_ready = 1'b1; cycle(); rd_ready = 1'b0;
        chk("t6_release", 32'(rif0.rd_valid_o), 0);

        // randomized traffic
        clear = 1'b1; cycle(); clear = 1'b0;
        for (int i = 0; i < 600; i++) begin
            hit = 4'($urandom);
            sample_en = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 63) == 0);
            cycle();
            check_flags();
            clear = 1'b0;
            if (i % 40 == 39) read_check($urandom_range(0, 7), "rnd");
        end

        // async reset in the middle of a response
        hit = 4'b1111; sample_en = 1'b1; cycle(); hit = '0;
        rd_idx = 3'd3; rd_req = 1'b1; cycle(); rd_req = 1'b0; cycle();
        chk("t1_in_resp", 32'(rif0.rd_valid_o), 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_valid_async", 32'(rif0.rd_valid_o), 0);
        chk("t1_cov_async", 32'(cov0), 0);
        chk("t1_rdy_async", 32'(rif0.rd_req_rdy_o), 1);
        chk("t1_count_async", 32'(rif0.rd_count_o), 0);
        cycle();
        rst = 1'b0;
        run_cycles(4, 4'b0000, 1'b1);
        read_check(3, "t1_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
